// File: rtl/can_crc_tx.sv
// can_crc_tx: CAN CRC-15 accumulator and serializer for the transmit path
module can_crc_tx #(
    parameter int               CRC_W = 15,
    parameter logic [CRC_W-1:0] POLY  = 15'h4599
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             bit_en,
    input  logic             data_in,
    input  logic             data_last,
    input  logic             abort,
    output logic             txd,
    output logic [CRC_W-1:0] crc_value,
    output logic             busy,
    output logic             crc_done
);
    typedef enum logic [1:0] {IDLE, DATA, CRC, DELIM} state_t;
    state_t           state_q;
    logic [3:0]       idx_q;
    logic [CRC_W-1:0] crc_q, crc_d;
    logic             txd_q, done_q;
    // next CRC value if the current data bit is shifted in
    always_comb crc_d = {crc_q[CRC_W-2:0], 1'b0} ^ ((data_in ^ crc_q[CRC_W-1]) ? POLY : '0);
    // frame sequencer: data bits, then CRC MSB first, then recessive delimiter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            crc_q   <= '0;
            txd_q   <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort) begin
                state_q <= IDLE;
                txd_q   <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        txd_q <= 1'b1;
                        if (start) begin
                            crc_q   <= '0;
                            state_q <= DATA;
                        end
                    end
                    DATA: if (bit_en) begin
                        txd_q <= data_in;
                        crc_q <= crc_d;
                        if (data_last) begin
                            state_q <= CRC;
                            idx_q   <= 4'd14;
                        end
                    end
                    CRC: if (bit_en) begin
                        txd_q <= crc_q[idx_q];
                        if (idx_q == 4'd0) state_q <= DELIM;
                        else idx_q <= idx_q - 4'd1;
                    end
                    DELIM: if (bit_en) begin
                        txd_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
    assign txd       = txd_q;
    assign crc_value = crc_q;
    assign busy      = state_q != IDLE;
    assign crc_done  = done_q;
endmodule

// File: tb/tb_can_crc_tx.sv
// tb_can_crc_tx: scoreboard bench for the CAN CRC-15 transmitter
module tb_can_crc_tx;
    logic        clk = 0, rst = 0, start = 0, bit_en = 0, data_in = 0, data_last = 0, abort = 0;
    logic        txd, busy, crc_done;
    logic [14:0] crc_value;
    logic [1:0]  sb[$];
    int          errors = 0, checks = 0;

    can_crc_tx dut (
        .clk(clk), .rst(rst), .start(start), .bit_en(bit_en), .data_in(data_in),
        .data_last(data_last), .abort(abort), .txd(txd), .crc_value(crc_value),
        .busy(busy), .crc_done(crc_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic s, input logic en, input logic d, input logic last, input logic ab);
        @(negedge clk);
        start = s; bit_en = en; data_in = d; data_last = last; abort = ab;
        @(posedge clk);
    endtask

    task automatic frame(input logic [7:0] bits, input int n, input logic [14:0] exp, input logic stall);
        cyc(1, 1, 1, 0, 0);
        #1 chk("start_busy", busy, 1);
        chk("start_txd", txd, 1);
        if (stall) cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) begin
            sb.push_back({bits[i], 1'b0});
            cyc(0, 1, bits[i], i == n - 1, 0);
        end
        #1 chk("crc_value", crc_value, exp);
        for (int i = 14; i >= 0; i--) begin
            sb.push_back({exp[i], 1'b0});
            cyc(0, 1, 0, 0, 0);
            if (stall && i == 10)
                repeat (5) begin
                    cyc(0, 0, 0, 0, 0);
                    #1 chk("stall_txd", txd, exp[10]);
                end
        end
        sb.push_back(2'b11);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        #1 chk("end_busy", busy, 0);
        chk("end_done", crc_done, 0);
    endtask

    // monitor: every effective strobe in a busy state yields one {txd, crc_done}
    initial forever begin
        logic       en;
        logic [1:0] e;
        @(negedge clk);
        #4 en = bit_en && busy && !abort && !rst;
        @(posedge clk);
        #1 if (en) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb_empty: got %b expected nothing", {txd, crc_done});
            end else begin
                e = sb.pop_front();
                chk("sb_txd_done", {txd, crc_done}, e);
            end
        end
    end

    initial begin
        #200000 $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        #1 rst = 1;
        #2 chk("rst_txd", txd, 1);
        chk("rst_crc", crc_value, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", crc_done, 0);
        @(negedge clk) rst = 0;
        frame(8'b0000_0001, 1, 15'h4599, 0);
        frame(8'b0000_0011, 2, 15'h0B32, 0);
        frame(8'b0000_0000, 8, 15'h0000, 0);
        frame(8'b0000_0011, 2, 15'h0B32, 1);
        cyc(1, 0, 0, 0, 0);
        sb.push_back(2'b10);
        cyc(0, 1, 1, 1, 0);
        for (int i = 14; i >= 8; i--) begin
            sb.push_back({15'h4599 >> i, 1'b0} & 2'b10);
            cyc(0, 1, 0, 0, 0);
        end
        cyc(0, 1, 0, 0, 1);
        #1 chk("abort_txd", txd, 1);
        chk("abort_busy", busy, 0);
        chk("abort_done", crc_done, 0);
        chk("abort_crc_hold", crc_value, 15'h4599);
        cyc(1, 0, 0, 0, 1);
        #1 chk("start_abort_busy", busy, 0);
        cyc(1, 0, 0, 0, 0);
        #1 chk("restart_crc", crc_value, 0);
        chk("restart_busy", busy, 1);
        cyc(0, 0, 0, 0, 1);
        #1 chk("abort2_busy", busy, 0);
        cyc(1, 0, 0, 0, 0);
        sb.push_back(2'b10);
        cyc(0, 1, 1, 0, 0);
        sb.push_back(2'b00);
        cyc(0, 1, 0, 0, 0);
        #1 chk("pre_rst_txd", txd, 0);
        #2 rst = 1;
        #1 chk("arst_txd", txd, 1);
        chk("arst_crc", crc_value, 0);
        chk("arst_busy", busy, 0);
        @(negedge clk) rst = 0;
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        #1 chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
